// File: rtl/sum_match_hlsm_pkg.sv
// Shared encodings for the sum-match state machine: controller states and
// compare relations selected by the mode input.
package sum_match_hlsm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_CMP  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [1:0] M_EQ = 2'b00;
  localparam logic [1:0] M_NE = 2'b01;
  localparam logic [1:0] M_GT = 2'b10;
  localparam logic [1:0] M_LT = 2'b11;

endpackage

// File: rtl/sum_match_hlsm_if.sv
// Request/response bundle of the sum-match block: start/clear controls,
// operands and target in; captured operands, sum, result and status out.
interface sum_match_hlsm_if #(
  parameter int W  = 4,
  parameter int CW = 8
);
  logic          b;
  logic          clr;
  logic [1:0]    mode;
  logic [W-1:0]  Di;
  logic [W-1:0]  Ei;
  logic [W-1:0]  F;
  logic [W-1:0]  Do;
  logic [W-1:0]  Eo;
  logic [W:0]    sum_o;
  logic          match;
  logic          done;
  logic          busy;
  logic [CW-1:0] match_cnt;

  modport master (
    output b, clr, mode, Di, Ei, F,
    input  Do, Eo, sum_o, match, done, busy, match_cnt
  );

  modport slave (
    input  b, clr, mode, Di, Ei, F,
    output Do, Eo, sum_o, match, done, busy, match_cnt
  );
endinterface

// File: rtl/sum_match_hlsm_rel.sv
// Combinational datapath: carry-preserving (or wrapping) W-bit adder and the
// eq/ne/gt/lt relation of a registered sum against a zero-extended target.
module sum_rel_unit
  import sum_match_hlsm_pkg::*;
#(
  parameter int W    = 4,
  parameter int WRAP = 0
) (
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [W:0]   sum_in,
  input  logic [W-1:0] tgt,
  input  logic [1:0]   mode,
  output logic [W:0]   sum,
  output logic         rel
);
  logic [W:0] full;
  logic [W:0] tgt_z;

  assign full  = {1'b0, op_a} + {1'b0, op_b};
  assign tgt_z = {1'b0, tgt};

  // Legacy wrap mode drops the carry so the sum never exceeds W bits.
  generate
    if (WRAP != 0) begin : g_wrap
      assign sum = {1'b0, full[W-1:0]};
    end else begin : g_carry
      assign sum = full;
    end
  endgenerate

  always_comb begin
    rel = 1'b0;
    case (mode)
      M_EQ:    rel = (sum_in == tgt_z);
      M_NE:    rel = (sum_in != tgt_z);
      M_GT:    rel = (sum_in >  tgt_z);
      M_LT:    rel = (sum_in <  tgt_z);
      default: rel = 1'b0;
    endcase
  end
endmodule

// File: rtl/sum_match_hlsm.sv
// Sum-match HLSM: capture operands on a start request, add, compare against a
// target under a run-time relation, pulse done and count matches.
module sum_match_hlsm
  import sum_match_hlsm_pkg::*;
#(
  parameter int W    = 4,
  parameter int CW   = 8,
  parameter int WRAP = 0
) (
  input  logic            clk,
  input  logic            rst,
  sum_match_hlsm_if.slave bus
);
  state_t        state;
  state_t        nxt;
  logic [W-1:0]  d_q;
  logic [W-1:0]  e_q;
  logic [W-1:0]  f_q;
  logic [1:0]    mode_q;
  logic [W:0]    sum_q;
  logic [W:0]    sum_nxt;
  logic          match_q;
  logic          rel;
  logic [CW-1:0] cnt_q;
  logic          cap;
  logic          in_calc;
  logic          in_cmp;

  assign cap     = (state == S_IDLE) && bus.b;
  assign in_calc = (state == S_CALC);
  assign in_cmp  = (state == S_CMP);

  sum_rel_unit #(.W(W), .WRAP(WRAP)) u_rel (
    .op_a   (d_q),
    .op_b   (e_q),
    .sum_in (sum_q),
    .tgt    (f_q),
    .mode   (mode_q),
    .sum    (sum_nxt),
    .rel    (rel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (bus.b) nxt = S_CALC;
      S_CALC:  nxt = S_CMP;
      S_CMP:   nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // clr outranks both the capture and the mismatch zeroing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q <= '0;
      e_q <= '0;
    end else if (bus.clr) begin
      d_q <= '0;
      e_q <= '0;
    end else if (cap) begin
      d_q <= bus.Di;
      e_q <= bus.Ei;
    end else if (in_cmp && !rel) begin
      d_q <= '0;
      e_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_q    <= '0;
      mode_q <= M_EQ;
    end else if (cap) begin
      f_q    <= bus.F;
      mode_q <= bus.mode;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         sum_q <= '0;
    else if (in_calc) sum_q <= sum_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        match_q <= 1'b0;
    else if (in_cmp) match_q <= rel;
  end

  // Saturating match counter; a coincident clr swallows the increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    cnt_q <= '0;
    else if (bus.clr)                            cnt_q <= '0;
    else if (in_cmp && rel && cnt_q != '1)       cnt_q <= cnt_q + CW'(1);
  end

  assign bus.Do        = d_q;
  assign bus.Eo        = e_q;
  assign bus.sum_o     = sum_q;
  assign bus.match     = match_q;
  assign bus.done      = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.match_cnt = cnt_q;
endmodule

// File: doc/sum_match_hlsm.md
# sum_match_hlsm

Parametrised successor of the 4-bit D/E sum-match high-level state machine. It captures two W-bit operands on a start request, forms their sum, and compares the sum against a W-bit target under a run-time relation (eq/ne/gt/lt). It reports the result with a one-cycle done pulse and keeps a saturating count of matches. It sits behind the same start-button style input as the existing controller/datapath pair and replaces it where wider operands, other relations or carry-preserving arithmetic are needed.

## Interface
- W, 4, operand/target width (≥2)
- CW, 8, match-counter width (≥1)
- WRAP, 0, 1 = sum truncated to W bits (legacy behaviour); 0 = sum keeps carry (W+1 bits)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- b  in  1  start request, sampled only in IDLE
- clr  in  1  synchronous clear of match_cnt, Do, Eo (any state)
- mode  in  2  relation: 00 eq, 01 ne, 10 sum>F, 11 sum<F
- Di, Ei  in  W  operands
- F  in  W  target
- Do, Eo  out  W  captured operands (zeroed on mismatch)
- sum_o  out  W+1  registered sum (MSB forced 0 when WRAP=1)
- match  out  1  result of last completed compare
- done  out  1  one-cycle completion pulse
- busy  out  1  high in any state other than IDLE
- match_cnt  out  CW  saturating count of matches

## Operation
- States: IDLE → CALC → CMP → DONE → IDLE; encoding 2 bits.
- IDLE: busy=0. If b=1 at an edge, latch Di→Do, Ei→Eo, F and mode into internal registers, then go to CALC. Otherwise hold.
- CALC: sum_o ← Do+Eo, with width per WRAP. Go to CMP.
- CMP: evaluate the relation of sum_o vs zero-extended F and register the result into match.
  - On match: match_cnt increments, saturating at 2^CW−1.
  - On mismatch: Do, Eo load 0.
  - Go to DONE.
- DONE: done=1, then go to IDLE unconditionally. b is ignored here.
- b while busy: ignored, not queued. Di/Ei/F/mode changes after capture have no effect.
- clr=1: match_cnt, Do, Eo ← 0 at the edge and take priority over loads in the same cycle. State, sum_o and match are unaffected.
- clr with a CMP match in the same cycle: the count clears and the increment is lost.
- WRAP=0 with W=4: 15+15=30 never matches eq for any F; gt holds for every F.

## Timing
- Reset (rst=0, asynchronous): state=IDLE; Do=Eo=0; sum_o=0; match=0; done=0; busy=0; match_cnt=0.
- Reset release is synchronous to clk via the flops' normal sampling. The first b is accepted at the first edge with rst=1.
- Latency: b sampled at edge k → CALC during cycle k..k+1, CMP during k+1..k+2, DONE during k+2..k+3. done is high for exactly one cycle after edge k+2; match and sum_o are valid from the same edge.
- Back-to-back: b held high re-captures at the edge after DONE. Minimum request spacing is 4 cycles.
- Reset asserted mid-operation aborts immediately: no done, no count change.
- match and sum_o hold until the next CMP/CALC.

## Structure
- Shared package: state encoding constants (S_IDLE, S_CALC, S_CMP, S_DONE) and mode constants (M_EQ, M_NE, M_GT, M_LT).
- One sub-module is natural: sum_rel_unit (combinational W-bit adder with carry plus eq/gt/lt relation select, parametrised by W and WRAP).
- Registers use async active-low reset flops with load enable.

## Test plan
- Reset: drive rst=0 mid-CALC → all outputs 0 immediately, state IDLE, no done pulse after release.
- W=4, WRAP=0, mode=eq, Di=3, Ei=5, F=8, b pulse → done 3 cycles later, match=1, sum_o=8, Do=3, Eo=5, match_cnt=1.
- W=4, WRAP=0, mode=eq, Di=15, Ei=15, F=14 → sum_o=30, match=0, Do=Eo=0. Same stimulus with WRAP=1 → sum_o=14, match=1.
- Modes with Di=2, Ei=2: F=3 with gt → 1; F=5 with lt → 1; F=4 with ne → 0. Count increments only on the matches.
- CW=2: five consecutive matches → match_cnt 1,2,3,3,3. clr asserted coincident with a CMP match → match_cnt=0.
- b held high continuously with Di changing every cycle → captures only at IDLE edges (one every 4 cycles). Captured values equal Di at those edges.
